ysyx_22050598_gnrl_pipe_skid: RTL and testbench

- Two-entry valid/ready pipeline stage (output register plus skid register) between core pipeline stages, e.g. IF→ID and ID→EX.
- Breaks the combinational ready path: upstream ready depends only on internal state and flush, never on downstream ready.
- Supplies the load-enabled payload registers that hold stage data, plus a synchronous flush for branch/trap redirect.

---
 rtl/ysyx_22050598_gnrl_pipe_skid_pkg.sv | 13 +
 rtl/ysyx_22050598_gnrl_pipe_skid_dfflrh.sv | 20 ++
 rtl/ysyx_22050598_gnrl_pipe_skid.sv | 96 +++++++++
 tb/tb_ysyx_22050598_gnrl_pipe_skid.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ysyx_22050598_gnrl_pipe_skid_pkg.sv
// Shared definitions for the skid pipeline stage: state encodings and default payload width.
package ysyx_22050598_gnrl_pipe_skid_pkg;

  localparam int PIPE_DW = 32;

  // Encoded as {skid_vld, main_vld}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/ysyx_22050598_gnrl_pipe_skid_dfflrh.sv
// Load-enabled flop with asynchronous active-high reset to zero.
module ysyx_22050598_gnrl_dfflrh #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ysyx_22050598_gnrl_pipe_skid.sv
// Two-entry valid/ready pipeline stage (main + skid register) with synchronous flush.
module ysyx_22050598_gnrl_pipe_skid
  import ysyx_22050598_gnrl_pipe_skid_pkg::*;
#(
  parameter int DW = PIPE_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [1:0]    occ
);

  logic          main_vld, skid_vld;
  logic          main_vld_nxt, skid_vld_nxt;
  logic [DW-1:0] main_dat, skid_dat;
  logic [DW-1:0] main_dat_nxt;
  logic          main_ld, skid_ld;
  logic          i_hs, o_hs;
  logic [1:0]    state;

  // Upstream ready looks only at registered state and flush, never at o_rdy.
  assign i_rdy = ~skid_vld & ~flush;
  assign o_vld = main_vld;
  assign o_dat = main_dat;
  assign i_hs  = i_vld & i_rdy;
  assign o_hs  = o_vld & o_rdy;
  assign state = {skid_vld, main_vld};
  assign occ   = {1'b0, main_vld} + {1'b0, skid_vld};

  always_comb begin
    main_vld_nxt = main_vld;
    skid_vld_nxt = skid_vld;
    main_dat_nxt = i_dat;
    main_ld      = 1'b0;
    skid_ld      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (i_hs) begin
          main_vld_nxt = 1'b1;
          main_ld      = 1'b1;
        end
      end
      ST_ONE: begin
        if (i_hs && o_hs) begin
          main_ld = 1'b1;
        end else if (i_hs) begin
          skid_vld_nxt = 1'b1;
          skid_ld      = 1'b1;
        end else if (o_hs) begin
          main_vld_nxt = 1'b0;
        end
      end
      ST_FULL: begin
        if (o_hs) begin
          skid_vld_nxt = 1'b0;
          main_dat_nxt = skid_dat;
          main_ld      = 1'b1;
        end
      end
      default: begin
        main_vld_nxt = 1'b0;
        skid_vld_nxt = 1'b0;
      end
    endcase
    // Flush kills buffered entries; stale data may remain behind cleared valids.
    if (flush) begin
      main_vld_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
      main_ld      = 1'b0;
      skid_ld      = 1'b0;
    end
  end

  ysyx_22050598_gnrl_dfflrh #(.DW(1)) u_main_vld (
    .clk(clk), .rst(rst), .ld(1'b1), .d(main_vld_nxt), .q(main_vld)
  );

  ysyx_22050598_gnrl_dfflrh #(.DW(1)) u_skid_vld (
    .clk(clk), .rst(rst), .ld(1'b1), .d(skid_vld_nxt), .q(skid_vld)
  );

  ysyx_22050598_gnrl_dfflrh #(.DW(DW)) u_main_dat (
    .clk(clk), .rst(rst), .ld(main_ld), .d(main_dat_nxt), .q(main_dat)
  );

  ysyx_22050598_gnrl_dfflrh #(.DW(DW)) u_skid_dat (
    .clk(clk), .rst(rst), .ld(skid_ld), .d(i_dat), .q(skid_dat)
  );

endmodule

// File: tb/tb_ysyx_22050598_gnrl_pipe_skid.sv
// Scoreboard bench for the skid pipeline stage: directed scenarios then random valid/ready traffic.
module tb_ysyx_22050598_gnrl_pipe_skid;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [1:0]    occ;

  int            err_cnt = 0;
  int            chk_cnt = 0;
  int            deliv_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic          last_acc;
  logic          hold_prev;
  logic [DW-1:0] prev_dat;

  always #5 clk = ~clk;

  ysyx_22050598_gnrl_pipe_skid #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat),
    .occ(occ)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic tick();
    logic          r0, exp_rdy, do_in, do_out;
    logic [DW-1:0] in_dat;
    #2;
    r0 = i_rdy;
    o_rdy = ~o_rdy;
    #1;
    chk("rdy_comb", i_rdy, r0);
    o_rdy = ~o_rdy;
    #1;
    exp_rdy = (exp_q.size() < 2) && !flush;
    chk("i_rdy", i_rdy, exp_rdy);
    chk("o_vld", o_vld, exp_q.size() > 0);
    chk("occ", occ, exp_q.size());
    if (exp_q.size() > 0) chk("o_dat", o_dat, exp_q[0]);
    if (hold_prev) chk("o_dat_stable", o_dat, prev_dat);
    do_in  = i_vld && exp_rdy;
    do_out = (exp_q.size() > 0) && o_rdy;
    in_dat = i_dat;
    hold_prev = o_vld && !o_rdy && !flush;
    prev_dat  = o_dat;
    $display("t=%0t vld=%0b rdy=%0b dat=%h | o_vld=%0b o_rdy=%0b o_dat=%h occ=%0d flush=%0b",
             $time, i_vld, i_rdy, i_dat, o_vld, o_rdy, o_dat, occ, flush);
    @(posedge clk);
    if (do_out) begin
      void'(exp_q.pop_front());
      deliv_cnt++;
    end
    if (do_in) exp_q.push_back(in_dat);
    if (flush) exp_q.delete();
    last_acc = do_in;
    @(negedge clk);
  endtask

  initial begin
    int d0;
    rst = 1'b1; flush = 1'b0; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b1;
    last_acc = 1'b0; hold_prev = 1'b0; prev_dat = '0;
    #1;
    chk("rst_i_rdy", i_rdy, 1);
    chk("rst_o_vld", o_vld, 0);
    chk("rst_o_dat", o_dat, 0);
    chk("rst_occ", occ, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 1: single transfer
    i_vld = 1'b1; i_dat = 32'hA5A5_0001; tick();
    i_vld = 1'b0; tick(); tick();

    // 2: streaming
    for (int k = 0; k < 8; k++) begin
      i_vld = 1'b1; i_dat = 32'h10 + k; tick();
    end
    i_vld = 1'b0; tick(); tick();

    // 3: backpressure into the skid entry
    o_rdy = 1'b0;
    i_vld = 1'b1; i_dat = 32'h21; tick();
    i_dat = 32'h22; tick();
    i_dat = 32'h23; tick();
    chk("skid_held", last_acc, 0);
    o_rdy = 1'b1;
    for (int k = 0; k < 4 && !last_acc; k++) tick();
    chk("skid_accept", last_acc, 1);
    i_vld = 1'b0; tick(); tick();

    // 4: flush from FULL
    o_rdy = 1'b0;
    i_vld = 1'b1; i_dat = 32'h31; tick();
    i_dat = 32'h32; tick();
    d0 = deliv_cnt;
    o_rdy = 1'b1; i_dat = 32'h33; flush = 1'b1; tick();
    flush = 1'b0; i_vld = 1'b0;
    chk("flush_deliv", deliv_cnt - d0, 1);
    tick(); tick();

    // 5: async reset while FULL
    o_rdy = 1'b0;
    i_vld = 1'b1; i_dat = 32'h41; tick();
    i_dat = 32'h42; tick();
    i_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_o_vld", o_vld, 0);
    chk("arst_o_dat", o_dat, 0);
    chk("arst_occ", occ, 0);
    chk("arst_i_rdy", i_rdy, 1);
    exp_q.delete(); hold_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0; o_rdy = 1'b1;
    i_vld = 1'b1; i_dat = 32'h43; tick();
    i_vld = 1'b0; tick(); tick();

    // 6: random valid/ready with occasional flush
    for (int c = 0; c < 10000; c++) begin
      if (!(i_vld && !last_acc)) begin
        i_vld = ($urandom_range(0, 3) != 0);
        i_dat = $urandom();
      end
      o_rdy = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 99) == 0);
      tick();
      if (flush) begin
        flush = 1'b0;
        i_vld = 1'b0;
      end
    end
    i_vld = 1'b0; flush = 1'b0; o_rdy = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
